barrel_shifter_pipe: RTL and testbench
======================================

# barrel_shifter_pipe

Pipelined, parametrised barrel shifter with a valid/ready stream interface. It supports rotate, logical shift and arithmetic shift in both directions. Shift amount, width and depth are set by parameters. It replaces the single-cycle combinational shifter wherever a datapath needs registered stages, backpressure or shift modes other than rotate.

## Interface
- `BW_DATA`, 8: data width in bits; must be ≥ 2.
- `BW_CTRL`, 3: shift-amount width in bits. It is also the pipeline depth, with one register stage per amount bit.
- `i_clk` input 1: clock; all logic is on the rising edge.
- `i_rstn` input 1: reset, synchronous, active-low.
- `i_valid` input 1: input beat valid.
- `o_ready` output 1: block can accept a beat this cycle.
- `i_a` input BW_DATA: operand.
- `i_k` input BW_CTRL: shift amount, range 0 to 2^BW_CTRL−1.
- `i_left` input 1: direction; 1 = left, 0 = right.
- `i_mode` input 2: operation select.
  - 00: rotate.
  - 01: logical shift.
  - 10: arithmetic shift.
  - 11: reserved, treated as 00.
- `o_valid` output 1: output beat valid.
- `i_ready` input 1: downstream accepts the beat.
- `o_y` output BW_DATA: result.
- `o_zero` output 1: result is all-zero. Present only with `BARREL_SHIFTER_PIPE_ZERO_EN`.

## Operation
- Stage s (s = 0 … BW_CTRL−1) handles amount bit b = BW_CTRL−1−s.
  - When bit b of the beat's k is 1, the stage shifts or rotates by 2^b, then registers the result.
  - k, direction and mode travel with the data through every stage.
- Per-stage behaviour by mode:
  - Rotate: rotate by 2^b mod BW_DATA, so the total rotation is k mod BW_DATA.
  - Logical: vacated bits are filled with 0. If k ≥ BW_DATA the result is 0.
  - Arithmetic right: vacated bits are filled with the original MSB of `i_a`, which is carried in the pipeline. If k ≥ BW_DATA the result is all copies of the sign bit.
  - Arithmetic left: identical to logical left.
- k = 0 passes `i_a` through unchanged in every mode.
- Handshake:
  - A beat transfers into the block when `i_valid && o_ready`.
  - A beat transfers out when `o_valid && i_ready`.
  - Each stage holds a valid bit. Stage s loads from stage s−1 when its own slot is empty or stage s+1 accepts its beat.
  - `o_ready` = stage-0 load enable.
  - `o_valid` = valid bit of the last stage.
  - `o_y` is the data register of the last stage.
- There are no bubbles: sustained throughput is 1 beat/clock while `i_ready` stays high.
- Full pipeline (BW_CTRL beats held) with `i_ready` = 0:
  - `o_ready` = 0.
  - All stage registers hold their contents.
  - `o_y` and `o_valid` stay stable.
- Full pipeline with `i_ready` = 1 and `i_valid` = 1 in the same cycle: one beat leaves and one enters, and `o_ready` stays 1.
- Once `o_valid` is asserted, it must not drop, and `o_y` must not change, until the beat is accepted.
- While `i_valid` = 0, the input data, k, direction and mode are don't-care.

## Timing
- Reset (`i_rstn` = 0 at a rising edge) forces:
  - all stage valid bits = 0;
  - all data registers = 0;
  - `o_valid` = 0, `o_y` = 0, and `o_zero` = 1 if present.
- `o_ready` reads 1 in the first cycle after reset is released.
- Reset mid-stream discards every beat in flight, with nothing emitted afterwards.
- A beat is also ignored if `i_valid` is high in the same cycle that reset is sampled.
- Latency: a beat accepted at edge N appears with `o_valid` = 1 after edge N+BW_CTRL−1, i.e. BW_CTRL cycles, with no stall.
- Stalls add exactly one cycle per cycle that `i_ready` = 0 while `o_valid` = 1.
- `o_ready` is combinational from `i_ready` through the stage valid bits. No other comb path runs input to output.

## Configuration
- `BARREL_SHIFTER_PIPE_ZERO_EN` defined:
  - adds the output port `o_zero`;
  - it is registered in the last stage alongside `o_y`;
  - `o_zero` = 1 iff the registered `o_y` == 0;
  - it follows the same hold rule as `o_y`.
- Macro undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
Defaults BW_DATA = 8, BW_CTRL = 3 (latency 3) unless stated.
- Rotate: a = 0x81.
  - Left, k = 1 → 0x03.
  - Right, k = 1 → 0xC0.
  - Left, k = 0 → 0x81.
  - Each result appears 3 cycles after acceptance.
- Logical shifts:
  - 0xF0 right, k = 4 → 0x0F.
  - 0x0F left, k = 4 → 0xF0.
  - 0xFF right, k = 7 → 0x01.
  - BW_DATA = 5: 0x1F right, k = 7 → 0x00.
- Arithmetic shifts:
  - 0x80 right, k = 3 → 0xF0.
  - 0x40 right, k = 3 → 0x08.
  - 0x81 left, k = 1 → 0x02.
  - BW_DATA = 5: 0x10 right, k = 6 → 0x1F.
- Backpressure:
  - Stream beats 0x01 … 0x08 with rotate left, k = 1.
  - Hold `i_ready` = 0 for 5 cycles mid-stream.
  - Required: outputs are 0x02, 0x04, …, 0x10 in order, with no loss or duplication.
  - `o_ready` drops while the pipeline holds 3 beats.
  - `o_y` is stable while stalled.
- Reset mid-stream:
  - With 3 beats in flight, drive `i_rstn` = 0 for one edge.
  - Required: `o_valid` = 0 and `o_y` = 0 the next cycle.
  - No discarded beat ever emerges.
  - `o_ready` = 1 after release.
- Zero flag (with `BARREL_SHIFTER_PIPE_ZERO_EN`):
  - 0x0F logical right, k = 4 → `o_y` = 0x00, `o_zero` = 1.
  - 0x0F rotate right, k = 4 → `o_y` = 0xF0, `o_zero` = 0.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (rotate / logical / arithmetic, both directions) with valid/ready flow control.
// Optional output flag o_zero is compiled in with `define BARREL_SHIFTER_PIPE_ZERO_EN.
module barrel_shifter_pipe #(
  parameter int BW_DATA = 8,
  parameter int BW_CTRL = 3
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BW_DATA-1:0] i_a,
  input  logic [BW_CTRL-1:0] i_k,
  input  logic               i_left,
  input  logic [1:0]         i_mode,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BW_DATA-1:0] o_y
`ifdef BARREL_SHIFTER_PIPE_ZERO_EN
  ,
  output logic               o_zero
`endif
);

  localparam int         LAST     = BW_CTRL - 1;
  localparam logic [1:0] MODE_LOG = 2'b01;
  localparam logic [1:0] MODE_ARI = 2'b10;

  // One power-of-two step; anything other than logical/arithmetic (incl. reserved 11) rotates.
  function automatic logic [BW_DATA-1:0] shift_pow2(
    input logic [BW_DATA-1:0] x,
    input logic               sgn,
    input logic               left,
    input logic [1:0]         mode,
    input int                 amt
  );
    logic [2*BW_DATA-1:0] dbl;
    logic [BW_DATA-1:0]   res;
    int                   rot;
    rot = amt % BW_DATA;
    dbl = {x, x};
    res = x;
    case (mode)
      MODE_LOG: begin
        res = (amt >= BW_DATA) ? '0 : (left ? (x << amt) : (x >> amt));
      end
      MODE_ARI: begin
        if (left) begin
          res = (amt >= BW_DATA) ? '0 : (x << amt);
        end else if (amt >= BW_DATA) begin
          res = {BW_DATA{sgn}};
        end else begin
          dbl = {{BW_DATA{sgn}}, x} >> amt;
          res = dbl[BW_DATA-1:0];
        end
      end
      default: begin
        if (left) begin
          dbl = dbl << rot;
          res = dbl[2*BW_DATA-1:BW_DATA];
        end else begin
          dbl = dbl >> rot;
          res = dbl[BW_DATA-1:0];
        end
      end
    endcase
    return res;
  endfunction

  logic [BW_CTRL-1:0] stage_valid;
  logic [BW_CTRL-1:0] load_en;

  // A slot may load when it is empty or its occupant moves on this cycle.
  always_comb begin
    load_en       = '0;
    load_en[LAST] = !stage_valid[LAST] || i_ready;
    for (int s = LAST - 1; s >= 0; s--) begin
      load_en[s] = !stage_valid[s] || load_en[s + 1];
    end
  end

  generate
    for (genvar gi = 0; gi < BW_CTRL; gi++) begin : g_stage
      localparam int BIT = BW_CTRL - 1 - gi;
      localparam int AMT = 1 << BIT;

      logic [BW_DATA-1:0] src_data;
      logic [BW_DATA-1:0] shifted;
      logic [BW_DATA-1:0] data_q;
      logic [BIT:0]       src_k;
      logic [1:0]         src_mode;
      logic               src_valid;
      logic               src_left;
      logic               src_sign;
      logic               valid_q;

      if (gi == 0) begin : g_src
        assign src_data  = i_a;
        assign src_k     = i_k;
        assign src_mode  = i_mode;
        assign src_valid = i_valid;
        assign src_left  = i_left;
        assign src_sign  = i_a[BW_DATA-1];
      end else begin : g_src
        assign src_data  = g_stage[gi-1].data_q;
        assign src_k     = g_stage[gi-1].g_ctl.k_q;
        assign src_mode  = g_stage[gi-1].g_ctl.mode_q;
        assign src_valid = g_stage[gi-1].valid_q;
        assign src_left  = g_stage[gi-1].g_ctl.left_q;
        assign src_sign  = g_stage[gi-1].g_ctl.sign_q;
      end

      assign shifted         = src_k[BIT] ? shift_pow2(src_data, src_sign, src_left, src_mode, AMT)
                                          : src_data;
      assign stage_valid[gi] = valid_q;

      always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (load_en[gi]) begin
          valid_q <= src_valid;
          if (src_valid) begin
            data_q <= shifted;
          end
        end
      end

      // Control only needs to travel to stages that still have amount bits to apply.
      if (BIT > 0) begin : g_ctl
        logic [BIT-1:0] k_q;
        logic [1:0]     mode_q;
        logic           left_q;
        logic           sign_q;

        always_ff @(posedge i_clk) begin
          if (!i_rstn) begin
            k_q    <= '0;
            mode_q <= '0;
            left_q <= 1'b0;
            sign_q <= 1'b0;
          end else if (load_en[gi] && src_valid) begin
            k_q    <= src_k[BIT-1:0];
            mode_q <= src_mode;
            left_q <= src_left;
            sign_q <= src_sign;
          end
        end
      end
    end
  endgenerate

  assign o_ready = load_en[0];
  assign o_valid = stage_valid[LAST];
  assign o_y     = g_stage[LAST].data_q;

`ifdef BARREL_SHIFTER_PIPE_ZERO_EN
  logic zero_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      zero_q <= 1'b1;
    end else if (load_en[LAST] && g_stage[LAST].src_valid) begin
      zero_q <= (g_stage[LAST].shifted == '0);
    end
  end

  assign o_zero = zero_q;
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe: an 8-bit and a 5-bit instance share stimulus.
// Zero-flag checks are compiled in with BARREL_SHIFTER_PIPE_ZERO_EN.
module tb_barrel_shifter_pipe;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       dn_ready;
  logic       left;
  logic [7:0] a8;
  logic [4:0] a5;
  logic [2:0] k;
  logic [1:0] mode;
  logic       ready8, valid8, ready5, valid5;
  logic [7:0] y8;
  logic [4:0] y5;
`ifdef BARREL_SHIFTER_PIPE_ZERO_EN
  logic       zero8, zero5;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       use5;
    logic [7:0] a;
    logic [2:0] k;
    logic       left;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.BW_DATA(8), .BW_CTRL(3)) u_dut8 (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_valid (in_valid),
    .o_ready (ready8),
    .i_a     (a8),
    .i_k     (k),
    .i_left  (left),
    .i_mode  (mode),
    .o_valid (valid8),
    .i_ready (dn_ready),
    .o_y     (y8)
`ifdef BARREL_SHIFTER_PIPE_ZERO_EN
    ,
    .o_zero  (zero8)
`endif
  );

  barrel_shifter_pipe #(.BW_DATA(5), .BW_CTRL(3)) u_dut5 (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_valid (in_valid),
    .o_ready (ready5),
    .i_a     (a5),
    .i_k     (k),
    .i_left  (left),
    .i_mode  (mode),
    .o_valid (valid5),
    .i_ready (dn_ready),
    .o_y     (y5)
`ifdef BARREL_SHIFTER_PIPE_ZERO_EN
    ,
    .o_zero  (zero5)
`endif
  );

  // Sends one beat into an empty pipe and samples the output 2 and 3 cycles after acceptance.
  task automatic run_beat(input vec_t v, output logic early_v, output logic late_v,
                          output logic [7:0] y, output logic z);
    @(negedge clk);
    a8 = v.a; a5 = v.a[4:0]; k = v.k; left = v.left; mode = v.mode;
    in_valid = 1'b1; dn_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    early_v = v.use5 ? valid5 : valid8;
    @(posedge clk); #1;
    late_v = v.use5 ? valid5 : valid8;
    y      = v.use5 ? {3'b000, y5} : y8;
`ifdef BARREL_SHIFTER_PIPE_ZERO_EN
    z = v.use5 ? zero5 : zero8;
`else
    z = 1'b0;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid8 !== 1'b0 || y8 !== 8'h00) begin
      errors++;
      $display("FAIL reset_out8: valid=%b y=%h, required valid=0 y=00", valid8, y8);
    end
    checks++;
    if (valid5 !== 1'b0 || y5 !== 5'h00) begin
      errors++;
      $display("FAIL reset_out5: valid=%b y=%h, required valid=0 y=00", valid5, y5);
    end
`ifdef BARREL_SHIFTER_PIPE_ZERO_EN
    checks++;
    if (zero8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_zero: o_zero=%b, required 1", zero8);
    end
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready8 !== 1'b1 || valid8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0", ready8, valid8);
    end
  endtask

  task automatic test_rotate;
    vec_t tbl [6];
    logic ev, lv, z;
    logic [7:0] y;
    tbl[0] = '{1'b0, 8'h81, 3'd1, 1'b1, 2'b00, 8'h03};
    tbl[1] = '{1'b0, 8'h81, 3'd1, 1'b0, 2'b00, 8'hC0};
    tbl[2] = '{1'b0, 8'h81, 3'd0, 1'b1, 2'b00, 8'h81};
    tbl[3] = '{1'b0, 8'h81, 3'd5, 1'b0, 2'b00, 8'h0C};
    tbl[4] = '{1'b1, 8'h01, 3'd7, 1'b1, 2'b00, 8'h04};
    tbl[5] = '{1'b0, 8'h81, 3'd1, 1'b1, 2'b11, 8'h03};
    for (int i = 0; i < 6; i++) begin
      run_beat(tbl[i], ev, lv, y, z);
      checks++;
      if (ev !== 1'b0 || lv !== 1'b1 || y !== tbl[i].exp) begin
        errors++;
        $display("FAIL rotate[%0d]: valid@2/3=%b/%b y=%h, required 0/1 y=%h", i, ev, lv, y, tbl[i].exp);
      end
    end
  endtask

  task automatic test_logical;
    vec_t tbl [5];
    logic ev, lv, z;
    logic [7:0] y;
    tbl[0] = '{1'b0, 8'hF0, 3'd4, 1'b0, 2'b01, 8'h0F};
    tbl[1] = '{1'b0, 8'h0F, 3'd4, 1'b1, 2'b01, 8'hF0};
    tbl[2] = '{1'b0, 8'hFF, 3'd7, 1'b0, 2'b01, 8'h01};
    tbl[3] = '{1'b1, 8'h1F, 3'd7, 1'b0, 2'b01, 8'h00};
    tbl[4] = '{1'b0, 8'hA5, 3'd0, 1'b1, 2'b01, 8'hA5};
    for (int i = 0; i < 5; i++) begin
      run_beat(tbl[i], ev, lv, y, z);
      checks++;
      if (ev !== 1'b0 || lv !== 1'b1 || y !== tbl[i].exp) begin
        errors++;
        $display("FAIL logical[%0d]: valid@2/3=%b/%b y=%h, required 0/1 y=%h", i, ev, lv, y, tbl[i].exp);
      end
    end
  endtask

  task automatic test_arith;
    vec_t tbl [5];
    logic ev, lv, z;
    logic [7:0] y;
    tbl[0] = '{1'b0, 8'h80, 3'd3, 1'b0, 2'b10, 8'hF0};
    tbl[1] = '{1'b0, 8'h40, 3'd3, 1'b0, 2'b10, 8'h08};
    tbl[2] = '{1'b0, 8'h81, 3'd1, 1'b1, 2'b10, 8'h02};
    tbl[3] = '{1'b1, 8'h10, 3'd6, 1'b0, 2'b10, 8'h1F};
    tbl[4] = '{1'b0, 8'h80, 3'd7, 1'b0, 2'b10, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      run_beat(tbl[i], ev, lv, y, z);
      checks++;
      if (ev !== 1'b0 || lv !== 1'b1 || y !== tbl[i].exp) begin
        errors++;
        $display("FAIL arith[%0d]: valid@2/3=%b/%b y=%h, required 0/1 y=%h", i, ev, lv, y, tbl[i].exp);
      end
    end
  endtask

  task automatic test_backpressure;
    int         sent = 0;
    int         got = 0;
    int         occ = 0;
    logic       stalled_prev = 1'b0;
    logic       extra = 1'b0;
    logic [7:0] held = 8'h00;
    logic       exp_ready, acc_in, acc_out;
    @(negedge clk);
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      dn_ready = (cyc >= 4 && cyc < 9) ? 1'b0 : 1'b1;
      if (sent < 8) begin
        in_valid = 1'b1; a8 = 8'(sent + 1); k = 3'd1; left = 1'b1; mode = 2'b00;
      end else begin
        in_valid = 1'b0;
      end
      #4;
      exp_ready = dn_ready || (occ < 3);
      checks++;
      if (ready8 !== exp_ready) begin
        errors++;
        $display("FAIL bp_ready cyc %0d: o_ready=%b, required %b (occupancy %0d)", cyc, ready8, exp_ready, occ);
      end
      if (stalled_prev) begin
        checks++;
        if (valid8 !== 1'b1 || y8 !== held) begin
          errors++;
          $display("FAIL bp_hold cyc %0d: valid=%b y=%h, required valid=1 y=%h", cyc, valid8, y8, held);
        end
      end
      acc_in  = in_valid && exp_ready;
      acc_out = valid8 && dn_ready;
      if (acc_out) begin
        checks++;
        if (y8 !== 8'((got + 1) * 2)) begin
          errors++;
          $display("FAIL bp_data beat %0d: y=%h, required %h", got, y8, 8'((got + 1) * 2));
        end
        got++;
      end
      stalled_prev = valid8 && !dn_ready;
      held         = y8;
      occ          = occ + int'(acc_in) - int'(acc_out);
      sent         = sent + int'(acc_in);
      @(negedge clk);
    end
    in_valid = 1'b0;
    dn_ready = 1'b1;
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL bp_count: beats out=%0d, required 8", got);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (valid8 !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL bp_extra: o_valid seen after all 8 beats left, required none");
    end
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a8 = 8'(8'h11 * (i + 1)); k = 3'd2; left = 1'b0; mode = 2'b00;
      dn_ready = 1'b0;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    checks++;
    if (valid8 !== 1'b1 || ready8 !== 1'b0) begin
      errors++;
      $display("FAIL rm_full: valid=%b ready=%b, required valid=1 ready=0", valid8, ready8);
    end
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b1; a8 = 8'h55; k = 3'd0;
    @(posedge clk); #1;
    checks++;
    if (valid8 !== 1'b0 || y8 !== 8'h00) begin
      errors++;
      $display("FAIL rm_flush: valid=%b y=%h, required valid=0 y=00", valid8, y8);
    end
`ifdef BARREL_SHIFTER_PIPE_ZERO_EN
    checks++;
    if (zero8 !== 1'b1) begin
      errors++;
      $display("FAIL rm_zero: o_zero=%b, required 1", zero8);
    end
`endif
    @(negedge clk);
    rstn = 1'b1; in_valid = 1'b0; dn_ready = 1'b1;
    #1;
    checks++;
    if (ready8 !== 1'b1) begin
      errors++;
      $display("FAIL rm_ready: o_ready=%b, required 1", ready8);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (valid8 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rm_ghost: a discarded beat emerged after reset, required none");
    end
  endtask

`ifdef BARREL_SHIFTER_PIPE_ZERO_EN
  task automatic test_zero_flag;
    vec_t tbl [2];
    logic       zexp [2];
    logic       ev, lv, z;
    logic [7:0] y;
    tbl[0] = '{1'b0, 8'h0F, 3'd4, 1'b0, 2'b01, 8'h00};
    tbl[1] = '{1'b0, 8'h0F, 3'd4, 1'b0, 2'b00, 8'hF0};
    zexp[0] = 1'b1;
    zexp[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run_beat(tbl[i], ev, lv, y, z);
      checks++;
      if (lv !== 1'b1 || y !== tbl[i].exp || z !== zexp[i]) begin
        errors++;
        $display("FAIL zero[%0d]: valid=%b y=%h zero=%b, required valid=1 y=%h zero=%b",
                 i, lv, y, z, tbl[i].exp, zexp[i]);
      end
    end
  endtask
`endif

  initial begin
    rstn = 1'b0; in_valid = 1'b0; dn_ready = 1'b1;
    a8 = 8'h00; a5 = 5'h00; k = 3'd0; left = 1'b0; mode = 2'b00;
    test_reset;
    test_rotate;
    test_logical;
    test_arith;
    test_backpressure;
    test_reset_mid;
`ifdef BARREL_SHIFTER_PIPE_ZERO_EN
    test_zero_flag;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
